// File: rtl/nibble_alu.sv
// Nibble-wide ALU: pass-A, compare/subtract, pass-B, ADD and NOR, with the
// result, carry and zero flags held in registers (one-clock latency).
module nibble_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Out,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] OP_OUT = 3'b000;
    localparam logic [2:0] OP_CMP = 3'b001;
    localparam logic [2:0] OP_LD  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;

    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum     = '0;
        out_d   = '0;
        carry_d = 1'b0;
        unique case (opcode)
            OP_OUT: out_d = A;
            OP_CMP: begin
                // carry out of A + ~B + 1 is the no-borrow flag (A >= B)
                sum     = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                out_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OP_LD:  out_d = B;
            OP_ADD: begin
                sum     = {1'b0, A} + {1'b0, B};
                out_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OP_NOR: out_d = ~(A | B);
            default: begin
                out_d   = '0;
                carry_d = 1'b0;
            end
        endcase
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (en) begin
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign Out   = out_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_nibble_alu.sv
// Directed bench for nibble_alu: hand-computed vectors checked one clock
// after they are applied, plus reset, enable-hold and reserved-opcode cases.
module tb_nibble_alu;

    logic       clock;
    logic       reset;
    logic       en;
    logic [2:0] opcode;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Out;
    logic       carry;
    logic       zero;

    int checks = 0;
    int errors = 0;

    nibble_alu #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .opcode(opcode),
        .A     (A),
        .B     (B),
        .Out   (Out),
        .carry (carry),
        .zero  (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] eo, input logic ec, input logic ez);
        checks++;
        assert ({Out, carry, zero} === {eo, ec, ez})
        else begin
            errors++;
            $error("FAIL %s: observed Out=%b c=%b z=%b expected Out=%b c=%b z=%b",
                   tag, Out, carry, zero, eo, ec, ez);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clock);
        opcode = op;
        A      = a;
        B      = b;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        en     = 1'b1;
        opcode = 3'b011;
        A      = 4'hF;
        B      = 4'hF;

        #1;
        chk("reset_t0", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("reset_hold", 4'b0000, 1'b0, 1'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_release_add", 4'b1110, 1'b1, 1'b0);

        apply(3'b000, 4'd3, 4'd0);  chk("out_3",  4'b0011, 1'b0, 1'b0);
        apply(3'b000, 4'd9, 4'd0);  chk("out_9",  4'b1001, 1'b0, 1'b0);
        apply(3'b010, 4'd0, 4'd3);  chk("ld_3",   4'b0011, 1'b0, 1'b0);
        apply(3'b010, 4'd0, 4'd9);  chk("ld_9",   4'b1001, 1'b0, 1'b0);
        apply(3'b000, 4'd0, 4'd7);  chk("out_0",  4'b0000, 1'b0, 1'b1);

        apply(3'b001, 4'd10, 4'd3); chk("cmp_10_3",  4'b0111, 1'b1, 1'b0);
        apply(3'b001, 4'd4, 4'd4);  chk("cmp_4_4",   4'b0000, 1'b1, 1'b1);
        apply(3'b001, 4'd9, 4'd10); chk("cmp_9_10",  4'b1111, 1'b0, 1'b0);
        apply(3'b001, 4'd0, 4'd15); chk("cmp_0_15",  4'b0001, 1'b0, 1'b0);

        apply(3'b100, 4'd5, 4'd2);  chk("nor_5_2",   4'b1000, 1'b0, 1'b0);
        apply(3'b100, 4'd4, 4'd15); chk("nor_4_15",  4'b0000, 1'b0, 1'b1);

        apply(3'b011, 4'd3, 4'd3);  chk("add_3_3",   4'b0110, 1'b0, 1'b0);
        apply(3'b011, 4'd9, 4'd10); chk("add_9_10",  4'b0011, 1'b1, 1'b0);
        apply(3'b011, 4'd15, 4'd1); chk("add_15_1",  4'b0000, 1'b1, 1'b1);

        apply(3'b011, 4'd3, 4'd3);  chk("add_before_hold", 4'b0110, 1'b0, 1'b0);
        @(negedge clock);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(3'b100, 4'd4, 4'd15);
            chk("en0_hold", 4'b0110, 1'b0, 1'b0);
        end
        @(negedge clock);
        en = 1'b1;
        apply(3'b111, 4'd9, 4'd5);  chk("reserved_111", 4'b0000, 1'b0, 1'b1);
        apply(3'b101, 4'd15, 4'd15); chk("reserved_101", 4'b0000, 1'b0, 1'b1);

        apply(3'b011, 4'd9, 4'd10); chk("add_before_async", 4'b0011, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_mid", 4'b0000, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("async_reset_held", 4'b0000, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        apply(3'b001, 4'd12, 4'd5); chk("after_reset_cmp", 4'b0111, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
